ipv4_rx: RTL and testbench
==========================

Name: ipv4_rx

Overview:
- IPv4 receive header parser. Sits directly downstream of the MAC RX stage and consumes its payload stream, which starts at the first IPv4 header byte.
- Parses and checks the IPv4 header (options included), then strips it.
- Forwards only the datagram payload (Total Length trimmed, Ethernet padding removed) to the UDP layer with start/term/len framing.
- Drops non-UDP and malformed datagrams and flags the reason.

Parameters:
- DATA_W, 16: datapath width in bits. Only 16 is supported; an elaboration error is raised otherwise.
- LEN_W, $clog2(DATA_W/8+1): width of byte-count fields (localparam).
- PROTO, 8'd17: accepted IPv4 Protocol value (UDP).

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- cancel_i  in  1  abort current datagram (PHY/MAC error)
- valid_i  in  1  input word valid
- start_i  in  1  first word of datagram (header bytes 0-1), qualified by valid_i
- term_i  in  1  last word of Ethernet frame, qualified by valid_i
- data_i  in  DATA_W  wire byte n at [7:0], byte n+1 at [15:8]
- len_i  in  LEN_W  valid bytes in data_i (1..2); only meaningful with term_i
- valid_o  out  1  payload word valid
- start_o  out  1  first payload word
- term_o  out  1  last payload word
- data_o  out  DATA_W  payload, same byte order as data_i
- len_o  out  LEN_W  valid bytes in data_o
- src_addr_o  out  32  source address, stable from start_o until next start_i
- dst_addr_o  out  32  destination address, same stability as src_addr_o
- hdr_err_o  out  1  one-cycle pulse: header rejected
- len_err_o  out  1  one-cycle pulse: frame ended before Total Length reached

Behaviour:
- Reset (async, nreset=0): FSM=IDLE; all outputs 0; counters 0.
- Header field extraction uses big-endian 16-bit word W = {data_i[7:0], data_i[15:8]}. Header word index k counts from 0 at start_i.
  - k=0: version = data_i[7:4], IHL = data_i[3:0].
  - k=1: total_len = W.
  - k=4: protocol = data_i[15:8].
  - k=6,7: src_addr.
  - k=8,9: dst_addr.
  - k=10..2*IHL-1: options, ignored.
- FSM states IDLE, HEAD, DATA, DROP. All transitions occur only on cycles with valid_i=1, except cancel_i.
  - IDLE -> HEAD on start_i.
  - start_i in any state restarts parsing at k=0; the current datagram is abandoned silently.
  - HEAD: k increments per valid word. On the last header word (k = 2*IHL-1), the header is evaluated combinationally:
    - pass -> DATA.
    - fail -> DROP, and hdr_err_o pulses in that same cycle.
  - Fail conditions: version!=4; IHL<5; protocol!=PROTO; total_len < 4*IHL; checksum bad.
  - Version/IHL are checked at k=0: a fail goes to DROP immediately and pulses hdr_err_o.
  - term_i while in HEAD -> IDLE, len_err_o pulse.
  - DATA:
    - Remaining-byte counter rem is loaded with total_len - 4*IHL (16 bit) on the HEAD->DATA transition.
    - Each valid word emits valid_o=1 and data_o=data_i, with len_o = min(2, rem, term_i ? len_i : 2), and decrements rem by len_o.
    - start_o=1 on the first emitted word.
    - term_o=1 when rem - len_o == 0 -> DROP (consumes trailing Ethernet padding). If term_i arrives in that same cycle -> IDLE.
    - term_i with rem - len_o > 0 -> term_o=1 on that word, len_err_o pulse, -> IDLE.
    - rem=0 at load (empty payload): no output word; go directly to DROP (IDLE if term_i).
  - DROP: discard words; term_i -> IDLE.
  - cancel_i (any state, valid_i not required): -> IDLE next cycle.
    - If in DATA, emit no further words.
    - If a payload is in progress, len_err_o pulses.
- Checksum: 17-bit accumulator with end-around carry, folded every word. It sums all header words including k=5. Pass iff the final folded sum == 16'hFFFF. Evaluation is on the last header word using the current word combinationally; it adds no latency.
- Latency: data_o/valid_o are combinational from data_i (zero cycle). src/dst registered when captured.
- len_i=1 on a header word: the datagram is treated as truncated -> IDLE, len_err_o pulse.

Optional Feature:
- IPV4_CSUM_CHECK_EN defined: checksum failure is a fail condition as above.
- Undefined: the checksum accumulator is not instantiated; the checksum is never a fail condition; all other checks are unchanged.

Test Plan:
- IHL=5, proto=17, total_len=28, correct checksum, frame of 14 words + 32 padding bytes -> start_o on word 10; 4 payload words, len_o=2 each; term_o on the 4th; padding discarded; no error pulses.
- Same header but total_len=29 -> 5 output words; last word len_o=1 with term_o.
- Checksum word XOR 16'h0001 with IPV4_CSUM_CHECK_EN -> hdr_err_o pulse on word 9; no valid_o. Without the macro -> payload forwarded.
- protocol=6 -> hdr_err_o on word 9; all remaining words dropped until term_i.
- IHL=6 (one option word) -> start_o on word 12; src_addr_o/dst_addr_o match the header values.
- total_len=100 but term_i at word 20 -> term_o on word 20; len_err_o pulses. Also: cancel_i asserted mid-payload -> valid_o=0 from the next cycle; then a new start_i parses correctly.

Source files
------------

// File: rtl/ipv4_rx.sv
// ipv4_rx -- IPv4 receive header parser.
//
// Consumes the MAC RX payload stream (first word = IPv4 header bytes 0-1).
// It parses and checks the header, including options, and then strips it.
// Only the datagram payload is forwarded. The payload is trimmed to Total
// Length, so Ethernet padding is removed, and it carries start/term/len
// framing. Non-UDP and malformed datagrams are dropped and flagged.
//
// Optional build macro: IPV4_CSUM_CHECK_EN
//   defined   : the header checksum is accumulated and a bad sum rejects
//               the header.
//   undefined : no checksum accumulator; the checksum is never checked.
//
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   cancel_i               abort the current datagram (PHY/MAC error)
//   valid_i/start_i/term_i input word valid, first word, last frame word
//   data_i/len_i           input word (byte n at [7:0]), valid bytes on term
//   valid_o/start_o/term_o payload framing (combinational from data_i)
//   data_o/len_o           payload word and its valid byte count
//   src_addr_o/dst_addr_o  captured addresses, held until the next datagram
//   hdr_err_o              one-cycle pulse: header rejected
//   len_err_o              one-cycle pulse: datagram cut short
module ipv4_rx #(
  parameter  int          DATA_W = 16,
  parameter  logic [7:0]  PROTO  = 8'd17,
  localparam int          LEN_W  = $clog2(DATA_W/8+1)
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              term_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              term_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [31:0]       src_addr_o,
  output logic [31:0]       dst_addr_o,
  output logic              hdr_err_o,
  output logic              len_err_o
);

  if (DATA_W != 16) begin : g_bad_width
    $error("ipv4_rx: only DATA_W = 16 is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  k_q, k_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [7:0]  proto_q, proto_d;
  logic [15:0] rem_q, rem_d;
  logic        first_q, first_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;

  // A start word always restarts parsing at k=0, whatever the current state.
  logic             hdr_word_s;
  logic [4:0]       k_s;
  logic [3:0]       ihl_s;
  logic [15:0]      word_s;
  logic             last_hdr_s;
  logic [15:0]      hdr_bytes_s;
  logic [15:0]      payload_len_s;
  logic             vi_fail_s;
  logic             hdr_fail_s;
  logic             csum_bad_s;
  logic [LEN_W-1:0] len_avail_s;
  logic [LEN_W-1:0] len_out_s;
  logic [15:0]      rem_after_s;

  assign hdr_word_s    = valid_i && (start_i || (state_q == S_HEAD));
  assign k_s           = start_i ? 5'd0 : k_q;
  assign ihl_s         = start_i ? data_i[3:0] : ihl_q;
  assign word_s        = {data_i[7:0], data_i[15:8]};
  assign last_hdr_s    = (k_s == ({ihl_s, 1'b0} - 5'd1));
  assign hdr_bytes_s   = {10'd0, ihl_s, 2'b00};
  assign payload_len_s = tot_len_q - hdr_bytes_s;
  assign vi_fail_s     = (data_i[7:4] != 4'd4) || (data_i[3:0] < 4'd5);
  assign hdr_fail_s    = (proto_q != PROTO) || (tot_len_q < hdr_bytes_s) || csum_bad_s;

  // Bytes on this word: min(2, rem, len_i if last frame word).
  assign len_avail_s = term_i ? len_i : LEN_W'(2);
  assign len_out_s   = (rem_q < {{(16-LEN_W){1'b0}}, len_avail_s}) ? rem_q[LEN_W-1:0] : len_avail_s;
  assign rem_after_s = rem_q - {{(16-LEN_W){1'b0}}, len_out_s};

`ifdef IPV4_CSUM_CHECK_EN
  // One's-complement add with end-around carry; the result never overflows.
  function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] w);
    logic [16:0] s;
    s = {1'b0, acc} + {1'b0, w};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  logic [15:0] csum_q;
  logic [15:0] csum_next_s;

  assign csum_next_s = csum_add(start_i ? 16'd0 : csum_q, word_s);
  assign csum_bad_s  = (csum_next_s != 16'hFFFF);

  // Running header checksum, restarted by every start word.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      csum_q <= 16'd0;
    end else if (hdr_word_s && !cancel_i) begin
      csum_q <= csum_next_s;
    end else begin
      csum_q <= csum_q;
    end
  end
`else
  assign csum_bad_s = 1'b0;
`endif

  // Next-state, field capture and combinational payload outputs.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    ihl_d      = ihl_q;
    tot_len_d  = tot_len_q;
    proto_d    = proto_q;
    rem_d      = rem_q;
    first_d    = first_q;
    src_d      = src_q;
    dst_d      = dst_q;
    valid_o    = 1'b0;
    start_o    = 1'b0;
    term_o     = 1'b0;
    data_o     = {DATA_W{1'b0}};
    len_o      = {LEN_W{1'b0}};
    hdr_err_o  = 1'b0;
    len_err_o  = 1'b0;

    if (cancel_i) begin
      state_d   = S_IDLE;
      len_err_o = (state_q == S_DATA);
    end else if (hdr_word_s) begin
      k_d = k_s + 5'd1;
      case (k_s)
        5'd0:    ihl_d          = data_i[3:0];
        5'd1:    tot_len_d      = word_s;
        5'd4:    proto_d        = data_i[15:8];
        5'd6:    src_d[31:16]   = word_s;
        5'd7:    src_d[15:0]    = word_s;
        5'd8:    dst_d[31:16]   = word_s;
        5'd9:    dst_d[15:0]    = word_s;
        default: k_d            = k_s + 5'd1;
      endcase
      if ((k_s == 5'd0) && vi_fail_s) begin
        hdr_err_o = 1'b1;
        state_d   = term_i ? S_IDLE : S_DROP;
      end else if (last_hdr_s && hdr_fail_s) begin
        hdr_err_o = 1'b1;
        state_d   = term_i ? S_IDLE : S_DROP;
      end else if (term_i) begin
        // Frame ended inside the header, unless it was a complete empty datagram.
        state_d   = S_IDLE;
        len_err_o = !(last_hdr_s && (payload_len_s == 16'd0) && (len_i == LEN_W'(2)));
      end else if (last_hdr_s) begin
        rem_d   = payload_len_s;
        first_d = 1'b1;
        state_d = (payload_len_s == 16'd0) ? S_DROP : S_DATA;
      end else begin
        state_d = S_HEAD;
      end
    end else if (valid_i && (state_q == S_DATA)) begin
      valid_o = 1'b1;
      data_o  = data_i;
      len_o   = len_out_s;
      start_o = first_q;
      first_d = 1'b0;
      rem_d   = rem_after_s;
      if (rem_after_s == 16'd0) begin
        term_o  = 1'b1;
        state_d = term_i ? S_IDLE : S_DROP;
      end else if (term_i) begin
        term_o    = 1'b1;
        len_err_o = 1'b1;
        state_d   = S_IDLE;
      end else begin
        state_d = S_DATA;
      end
    end else if (valid_i && (state_q == S_DROP)) begin
      state_d = term_i ? S_IDLE : S_DROP;
    end else begin
      state_d = state_q;
    end
  end

  // State and captured-field registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      k_q       <= 5'd0;
      ihl_q     <= 4'd0;
      tot_len_q <= 16'd0;
      proto_q   <= 8'd0;
      rem_q     <= 16'd0;
      first_q   <= 1'b0;
      src_q     <= 32'd0;
      dst_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ihl_q     <= ihl_d;
      tot_len_q <= tot_len_d;
      proto_q   <= proto_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
    end
  end

  assign src_addr_o = src_q;
  assign dst_addr_o = dst_q;

endmodule

// File: tb/tb_ipv4_rx.sv
// tb_ipv4_rx -- randomized self-checking bench for ipv4_rx.
// Frames are built as byte arrays. The expected payload window, framing and
// error pulses are derived from the header fields with plain arithmetic.
module tb_ipv4_rx;

  logic        clk = 1'b0;
  logic        nreset;
  logic        cancel_i, valid_i, start_i, term_i;
  logic [15:0] data_i;
  logic [1:0]  len_i;
  logic        valid_o, start_o, term_o;
  logic [15:0] data_o;
  logic [1:0]  len_o;
  logic [31:0] src_addr_o, dst_addr_o;
  logic        hdr_err_o, len_err_o;

  ipv4_rx dut (
    .clk(clk), .nreset(nreset), .cancel_i(cancel_i), .valid_i(valid_i),
    .start_i(start_i), .term_i(term_i), .data_i(data_i), .len_i(len_i),
    .valid_o(valid_o), .start_o(start_o), .term_o(term_o), .data_o(data_o),
    .len_o(len_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .hdr_err_o(hdr_err_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

`ifdef IPV4_CSUM_CHECK_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  byte unsigned fr[256];
  int flen;
  // Reference expectations for the current frame.
  int e_fail_w, e_first, e_nout, e_p, e_lenerr_w;
  logic [31:0] e_src, e_dst;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fold16(input int s);
    int r;
    r = s;
    while ((r >> 16) != 0) r = (r & 16'hFFFF) + (r >> 16);
    return r;
  endfunction

  task automatic build_frame(input int ver, input int ihl, input int tl, input int proto,
                             input bit bad_csum, input int f);
    int s;
    int ck;
    for (int i = 0; i < 256; i++) fr[i] = 8'($urandom_range(0, 255));
    fr[0] = 8'(((ver & 15) << 4) | (ihl & 15));
    fr[2] = 8'(tl >> 8);
    fr[3] = 8'(tl & 255);
    fr[9] = 8'(proto);
    fr[10] = 8'd0;
    fr[11] = 8'd0;
    if (ihl >= 5) begin
      s = 0;
      for (int w = 0; w < 2 * ihl; w++) s += fr[2*w] * 256 + fr[2*w+1];
      ck = (~fold16(s)) & 16'hFFFF;
      if (bad_csum) ck = ck ^ 1;
      fr[10] = 8'(ck >> 8);
      fr[11] = 8'(ck & 255);
    end
    flen = f;
  endtask

  // Derive expected outcome of the current frame from its header bytes.
  task automatic model_frame();
    int ver, ihl, tl, proto, s, lim;
    ver = fr[0] >> 4;
    ihl = fr[0] & 15;
    tl = fr[2] * 256 + fr[3];
    proto = fr[9];
    e_fail_w = -1; e_nout = 0; e_p = 0; e_lenerr_w = -1; e_first = 0;
    e_src = {fr[12], fr[13], fr[14], fr[15]};
    e_dst = {fr[16], fr[17], fr[18], fr[19]};
    if (ver != 4 || ihl < 5) begin
      e_fail_w = 0;
    end else begin
      s = 0;
      for (int w = 0; w < 2 * ihl; w++) s += fr[2*w] * 256 + fr[2*w+1];
      if (proto != 17 || tl < 4 * ihl || (CSUM_EN && fold16(s) != 16'hFFFF))
        e_fail_w = 2 * ihl - 1;
    end
    if (e_fail_w < 0) begin
      lim = (tl < flen) ? tl : flen;
      e_p = lim - 4 * ihl;
      e_nout = (e_p + 1) / 2;
      e_first = 2 * ihl;
      if (flen < tl) e_lenerr_w = (flen + 1) / 2 - 1;
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0; cancel_i = 1'b0;
    #2;
    check_eq("idle_valid", valid_o, 1'b0);
    check_eq("idle_hdr_err", hdr_err_o, 1'b0);
    check_eq("idle_len_err", len_err_o, 1'b0);
  endtask

  task automatic run_frame(input int cancel_after);
    int nw, oi, el;
    bit ev;
    nw = (flen + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      @(negedge clk);
      valid_i = 1'b1;
      start_i = (w == 0);
      term_i = (w == nw - 1);
      len_i = (term_i && (flen % 2 == 1)) ? 2'd1 : 2'd2;
      data_i = {fr[2*w+1], fr[2*w]};
      #2;
      oi = w - e_first;
      ev = (e_fail_w < 0) && (oi >= 0) && (oi < e_nout);
      check_eq("valid_o", valid_o, ev);
      if (ev) begin
        el = e_p - 2 * oi;
        if (el > 2) el = 2;
        check_eq("data_o", data_o, {fr[2*w+1], fr[2*w]});
        check_eq("len_o", len_o, el);
        check_eq("start_o", start_o, oi == 0);
        check_eq("term_o", term_o, oi == e_nout - 1);
        if (oi == 0) begin
          check_eq("src_addr", src_addr_o, e_src);
          check_eq("dst_addr", dst_addr_o, e_dst);
        end
      end
      check_eq("hdr_err_o", hdr_err_o, w == e_fail_w);
      check_eq("len_err_o", len_err_o, w == e_lenerr_w);
      if (cancel_after > 0 && ev && oi == cancel_after - 1) begin
        @(negedge clk);
        valid_i = 1'b0; start_i = 1'b0; term_i = 1'b0; cancel_i = 1'b1;
        #2;
        check_eq("cancel_len_err", len_err_o, 1'b1);
        check_eq("cancel_valid", valid_o, 1'b0);
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          cancel_i = 1'b0; valid_i = 1'b1; len_i = 2'd2;
          data_i = 16'($urandom_range(0, 65535));
          #2;
          check_eq("post_cancel_valid", valid_o, 1'b0);
          check_eq("post_cancel_len_err", len_err_o, 1'b0);
        end
        break;
      end
    end
    idle_cycle();
  endtask

  task automatic directed(input int ver, input int ihl, input int tl, input int proto,
                          input bit bad, input int f, input int cancel_after);
    build_frame(ver, ihl, tl, proto, bad, f);
    model_frame();
    run_frame(cancel_after);
  endtask

  initial begin
    int ver, ihl, ihl_e, tl, proto, f, ca;
    bit bad;
    nreset = 1'b0; cancel_i = 1'b0; valid_i = 1'b0; start_i = 1'b0;
    term_i = 1'b0; data_i = 16'd0; len_i = 2'd0;
    #12;
    check_eq("rst_valid", valid_o, 1'b0);
    check_eq("rst_src", src_addr_o, 32'd0);
    check_eq("rst_dst", dst_addr_o, 32'd0);
    check_eq("rst_errs", {hdr_err_o, len_err_o}, 2'b00);
    nreset = 1'b1;
    idle_cycle();

    directed(4, 5, 28, 17, 1'b0, 60, -1);   // 4 full payload words
    directed(4, 5, 29, 17, 1'b0, 60, -1);   // odd length, last len_o=1
    directed(4, 5, 28, 17, 1'b1, 60, -1);   // corrupted checksum
    directed(4, 5, 28, 6, 1'b0, 60, -1);    // TCP rejected
    directed(4, 6, 40, 17, 1'b0, 60, -1);   // one option word
    directed(4, 5, 100, 17, 1'b0, 40, -1);  // frame shorter than datagram
    directed(4, 5, 60, 17, 1'b0, 80, 3);    // cancel mid-payload
    directed(4, 5, 28, 17, 1'b0, 61, -1);   // clean parse after cancel
    directed(4, 5, 20, 17, 1'b0, 46, -1);   // empty payload
    directed(6, 5, 28, 17, 1'b0, 46, -1);   // bad version
    directed(4, 4, 28, 17, 1'b0, 46, -1);   // IHL too small
    directed(4, 5, 16, 17, 1'b0, 46, -1);   // total_len below header

    for (int n = 0; n < 200; n++) begin
      ver = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 15) : 4;
      ihl = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 4) : $urandom_range(5, 8);
      ihl_e = (ihl < 5) ? 5 : ihl;
      proto = ($urandom_range(0, 7) == 0) ? 6 : 17;
      bad = ($urandom_range(0, 7) == 0);
      tl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4 * ihl_e - 1)
                                       : 4 * ihl_e + $urandom_range(0, 40);
      f = 4 * ihl_e + 1 + $urandom_range(0, 50);
      build_frame(ver, ihl, tl, proto, bad, f);
      model_frame();
      ca = -1;
      if (e_nout >= 3 && $urandom_range(0, 7) == 0) ca = $urandom_range(1, e_nout - 1);
      run_frame(ca);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
